mealy_word_sequencer: RTL and testbench
=======================================

// Module: mealy_word_sequencer
// PURPOSE
//  Word-level controller for the 5-state Mealy sequence machine (S0..S4).
//  - Accepts a WIDTH-bit word over a valid/ready handshake.
//  - Streams the word LSB-first into the machine, one bit per clock, and gathers the Mealy output bits.
//  - Returns the gathered bits as one word over a second valid/ready handshake.
//  - Owns the machine through an enable-gated core, so machine state is frozen between words.
// PARAMETERS
//  WIDTH   8              bits per word; legal range 2..32
//  CNT_W   $clog2(WIDTH)  width of the bit counter (derived; do not override)
// PORTS
//  clk         in   1      rising-edge clock
//  rstn        in   1      asynchronous, active-low reset
//  in_valid    in   1      input word valid
//  in_ready    out  1      controller can accept a word
//  in_data     in   WIDTH  word to process; bit 0 is applied first
//  in_restart  in   1      sampled with in_data; 1 = force machine to S0 before bit 0
//  out_valid   out  1      result word valid
//  out_ready   in   1      consumer accepts the result
//  out_data    out  WIDTH  y bits; bit i = y produced while in_data[i] was applied
//  core_state  out  3      current machine state (debug/visibility)
//  busy        out  1      high in SHIFT and DONE
// BEHAVIOUR
//  Reset (async, rstn=0):
//   - ctrl=IDLE, machine=S0, counter=0, shift/result regs=0.
//   - Outputs: out_valid=0, out_data=0, core_state=3'd0, busy=0, in_ready=1 (in_ready is comb. from IDLE).
//  Core machine (advances only when en=1; clr is synchronous and has priority over en):
//   - S0: x=1 -> S4, x=0 -> S3.   S1: x=1 -> S4, x=0 -> S1.   S2: x=1 -> S0, x=0 -> S2.
//   - S3: x=1 -> S1, x=0 -> S2.   S4: x=1 -> S3, x=0 -> S2.
//   - y = 0 in S4; otherwise y = x (combinational). Illegal state -> S0.
//  Controller FSM:
//   - IDLE:
//     - in_ready=1.
//     - On in_valid at an edge: load the shift reg, counter=0, pass clr=in_restart to the core, go to SHIFT.
//   - SHIFT:
//     - en=1, x = shreg[0].
//     - At each edge: result[counter] <= y, shift the reg right, counter++.
//     - At the edge with counter==WIDTH-1, go to DONE.
//   - DONE:
//     - out_valid=1 and out_data=result, both held stable.
//     - On out_ready at an edge: out_valid->0, go to IDLE.
//  Timing and throughput:
//   - Latency: word accepted at edge T; out_valid is high after edge T+WIDTH.
//   - Minimum period: WIDTH+2 cycles per word (SHIFT, DONE, IDLE).
//  Boundary cases:
//   - The machine is not advanced in IDLE or DONE. Its state carries across words unless in_restart=1.
//   - in_valid while busy is ignored (in_ready=0); the upstream holds the word.
//   - out_ready in IDLE or SHIFT has no effect.
//   - Reset during SHIFT or DONE aborts the word with no output; the controller restarts in IDLE with the machine in S0.
// STRUCTURE
//  - Package mealy_seq_pkg holds:
//    - state_t enum S0..S4 (3 bits);
//    - ctrl_t enum IDLE/SHIFT/DONE;
//    - function next_state(state_t, x) implementing the transition table above.
//  - Sub-module mealy_seq_core (clk, rstn, en, clr, x, y, state): the enable-gated machine, one instance.
// TESTING
//  - Reset: rstn=0 for 2 cycles -> in_ready=1, out_valid=0, out_data=0, core_state=0, busy=0.
//  - Word 8'h01 with restart:
//    - out_data=8'h01, core_state=S2 when out_valid.
//    - out_valid rises exactly 8 edges after the accept edge.
//  - Word 8'hFF with restart -> out_data=8'h6D, core_state=S3.
//  - Back-to-back words with no restart, continuing from S3:
//    - next word 8'h00 -> out_data=8'h00, final core_state=S2;
//    - from S3 again, word 8'h01 -> out_data=8'h01, final core_state=S1.
//  - Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_data and core_state stay stable,
//    in_ready=0, and an offered in_valid is not consumed.
//  - Reset mid-word: rstn=0 at the 4th SHIFT cycle of 8'hFF -> out_valid never rises, core_state=0.
//    After release, a word 8'h01 with restart=0 -> out_data=8'h01.

Source files
------------

// File: rtl/mealy_seq_pkg.sv
`default_nettype none
// ============================================================================
// mealy_seq_pkg : state/controller encodings and the 5-state transition table
// Revision 1.0
// ============================================================================
package mealy_seq_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ctrl_t;

  function automatic state_t next_state(input state_t s, input logic x);
    state_t n;
    case (s)
      S0:      n = x ? S4 : S3;
      S1:      n = x ? S4 : S1;
      S2:      n = x ? S0 : S2;
      S3:      n = x ? S1 : S2;
      S4:      n = x ? S3 : S2;
      default: n = S0;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mealy_seq_core.sv
`default_nettype none
// ============================================================================
// mealy_seq_core : enable-gated 5-state Mealy machine, y = 0 in S4 else x
// Revision 1.0
// ============================================================================
module mealy_seq_core
  import mealy_seq_pkg::*;
(
  input  logic   clk,
  input  logic   rstn,
  input  logic   en,
  input  logic   clr,
  input  logic   x,
  output logic   y,
  output state_t state
);

  state_t r_state;
  state_t w_next;

  // clr wins over en so a restart always lands in S0 regardless of en
  always_comb begin
    w_next = r_state;
    if (clr) begin
      w_next = S0;
    end else if (en) begin
      w_next = next_state(r_state, x);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S0;
    end else begin
      r_state <= w_next;
    end
  end

  assign y     = (r_state == S4) ? 1'b0 : x;
  assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/mealy_word_sequencer.sv
`default_nettype none
// ============================================================================
// mealy_word_sequencer : streams a word LSB-first through the Mealy core and
//                        returns the gathered y bits as one word
// Revision 1.0
// ============================================================================
module mealy_word_sequencer
  import mealy_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_restart,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       core_state,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

  ctrl_t            r_ctrl;
  ctrl_t            w_ctrl_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;

  logic   w_accept;
  logic   w_en;
  logic   w_clr;
  logic   w_y;
  state_t w_core_state;

  mealy_seq_core u_core (
    .clk   (clk),
    .rstn  (rstn),
    .en    (w_en),
    .clr   (w_clr),
    .x     (r_shreg[0]),
    .y     (w_y),
    .state (w_core_state)
  );

  always_comb begin
    w_ctrl_nxt = r_ctrl;
    w_accept   = 1'b0;
    w_en       = 1'b0;
    w_clr      = 1'b0;
    case (r_ctrl)
      IDLE: begin
        if (in_valid) begin
          w_accept   = 1'b1;
          w_clr      = in_restart;
          w_ctrl_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_en = 1'b1;
        if (r_cnt == c_LAST) begin
          w_ctrl_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_ctrl_nxt = IDLE;
        end
      end
      default: w_ctrl_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ctrl <= IDLE;
    end else begin
      r_ctrl <= w_ctrl_nxt;
    end
  end

  // Result bit i captures y while bit i of the accepted word drives x
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shreg  <= '0;
      r_result <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_shreg <= in_data;
      r_cnt   <= '0;
    end else if (w_en) begin
      r_result[r_cnt] <= w_y;
      r_shreg         <= r_shreg >> 1;
      r_cnt           <= r_cnt + 1'b1;
    end
  end

  assign in_ready   = (r_ctrl == IDLE);
  assign out_valid  = (r_ctrl == DONE);
  assign busy       = (r_ctrl == SHIFT) || (r_ctrl == DONE);
  assign out_data   = r_result;
  assign core_state = w_core_state;

endmodule
`default_nettype wire

// File: tb/tb_mealy_word_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mealy_word_sequencer : directed words checked against a table-driven model
// Revision 1.0
// ============================================================================
module tb_mealy_word_sequencer;

  localparam int W = 8;

  logic         clk        = 1'b0;
  logic         rstn       = 1'b1;
  logic         in_valid   = 1'b0;
  logic         in_restart = 1'b0;
  logic         out_ready  = 1'b0;
  logic [W-1:0] in_data    = '0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [W-1:0] out_data;
  logic [2:0]   core_state;

  int n_vec = 0;
  int n_bad = 0;

  mealy_word_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_restart (in_restart),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .core_state (core_state),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Transition table indexed by state: T0 for x=0, T1 for x=1
  int T0 [5] = '{3, 1, 2, 2, 2};
  int T1 [5] = '{4, 4, 0, 1, 3};

  function automatic int step(input int s, input logic x);
    if (s < 0 || s > 4) return 0;
    return x ? T1[s] : T0[s];
  endfunction

  function automatic logic [W-1:0] word_y(input int s0, input logic [W-1:0] d);
    logic [W-1:0] r;
    int s;
    s = s0;
    r = '0;
    for (int i = 0; i < W; i++) begin
      r[i] = (s == 4) ? 1'b0 : d[i];
      s    = step(s, d[i]);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 shifting, 2 holding result
  int           m_ph    = 0;
  int           m_cnt   = 0;
  int           m_state = 0;
  logic [W-1:0] m_word  = '0;
  logic [W-1:0] m_res   = '0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_ph    <= 0;
      m_cnt   <= 0;
      m_state <= 0;
      m_res   <= '0;
    end else begin
      case (m_ph)
        0: if (in_valid) begin
          m_ph    <= 1;
          m_cnt   <= 0;
          m_word  <= in_data;
          m_state <= in_restart ? 0 : m_state;
          m_res   <= word_y(in_restart ? 0 : m_state, in_data);
        end
        1: begin
          m_state <= step(m_state, m_word[m_cnt]);
          m_cnt   <= m_cnt + 1;
          if (m_cnt == W - 1) m_ph <= 2;
        end
        default: if (out_ready) m_ph <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("in_ready",   {31'd0, in_ready},   {31'd0, m_ph == 0});
    chk("out_valid",  {31'd0, out_valid},  {31'd0, m_ph == 2});
    chk("busy",       {31'd0, busy},       {31'd0, m_ph != 0});
    chk("core_state", {29'd0, core_state}, m_state);
    if (m_ph == 2) chk("out_data", {24'd0, out_data}, {24'd0, m_res});
  end

  task automatic send(input logic [W-1:0] d, input logic r);
    int g;
    @(negedge clk);
    in_valid   = 1'b1;
    in_data    = d;
    in_restart = r;
    g = 0;
    while (!in_ready && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_restart = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
    end
    if (!out_valid) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_word(input string name, input logic [W-1:0] d, input logic r,
                          input logic [W-1:0] exp_d, input logic [2:0] exp_s);
    int lat;
    send(d, r);
    wait_done(lat);
    chk({name, "_latency"}, lat, 32'd8);
    chk({name, "_data"},  {24'd0, out_data},   {24'd0, exp_d});
    chk({name, "_state"}, {29'd0, core_state}, {29'd0, exp_s});
    consume();
  endtask

  initial begin
    logic [W-1:0] hold_d;
    logic [2:0]   hold_s;
    int           lat;
    logic         seen;

    #0 rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",   {31'd0, in_ready},   32'd1);
    chk("rst_out_valid",  {31'd0, out_valid},  32'd0);
    chk("rst_out_data",   {24'd0, out_data},   32'd0);
    chk("rst_core_state", {29'd0, core_state}, 32'd0);
    chk("rst_busy",       {31'd0, busy},       32'd0);
    #2 rstn = 1'b1;

    run_word("w01_restart", 8'h01, 1'b1, 8'h01, 3'd2);
    run_word("wFF_restart", 8'hFF, 1'b1, 8'h6D, 3'd3);
    run_word("w00_from_s3", 8'h00, 1'b0, 8'h00, 3'd2);
    run_word("wFF_again",   8'hFF, 1'b1, 8'h6D, 3'd3);
    run_word("w01_from_s3", 8'h01, 1'b0, 8'h01, 3'd1);

    // Backpressure in DONE with a competing word offered
    send(8'hA5, 1'b1);
    wait_done(lat);
    @(negedge clk);
    in_valid   = 1'b1;
    in_data    = 8'h3C;
    in_restart = 1'b1;
    hold_d     = out_data;
    hold_s     = core_state;
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid",  {31'd0, out_valid},  32'd1);
      chk("bp_out_data",   {24'd0, out_data},   {24'd0, hold_d});
      chk("bp_core_state", {29'd0, core_state}, {29'd0, hold_s});
      chk("bp_in_ready",   {31'd0, in_ready},   32'd0);
    end
    chk("bp_data_lit",  {24'd0, out_data},   32'hA5);
    chk("bp_state_lit", {29'd0, core_state}, 32'd1);
    in_valid   = 1'b0;
    in_restart = 1'b0;
    consume();
    @(negedge clk);
    chk("bp_not_consumed_busy",  {31'd0, busy},     32'd0);
    chk("bp_not_consumed_ready", {31'd0, in_ready}, 32'd1);

    // Reset asserted in the 4th SHIFT cycle of 8'hFF
    send(8'hFF, 1'b1);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_core_state", {29'd0, core_state}, 32'd0);
    chk("abort_out_valid",  {31'd0, out_valid},  32'd0);
    chk("abort_busy",       {31'd0, busy},       32'd0);
    #2 rstn = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_output", {31'd0, seen}, 32'd0);
    run_word("w01_after_abort", 8'h01, 1'b0, 8'h01, 3'd2);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
